// File: rtl/fp_arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width
// used by the shift-add multiplier and the restoring divider.
package fp_arith_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fp_shift_add_mult.sv
// Sequential shift-add multiplier reconstructing a dividend: result = q*b + rem.
// Fixed latency of N RUN cycles, one-cycle done pulse, result held until the next completion.
module fp_shift_add_mult
    import fp_arith_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   q,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   rem,
    output logic [2*N-1:0] result,
    output logic           busy,
    output logic           done
);

    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    fsm_state_t     state_r;
    fsm_state_t     state_next_s;
    logic [N-1:0]   mplier_r;
    logic [N-1:0]   mcand_r;
    logic [2*N-1:0] acc_r;
    logic [2*N-1:0] addend_s;
    logic [2*N-1:0] acc_sum_s;
    logic [2*N-1:0] result_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic           last_iter_s;

    assign last_iter_s = (cnt_r == LAST_ITER);

    // Single 2N-bit adder: accumulate the multiplicand weighted by the current bit position.
    always_comb begin
        addend_s = {(2*N){1'b0}};
        if (mplier_r[0]) begin
            addend_s = {{N{1'b0}}, mcand_r} << cnt_r;
        end else begin
            addend_s = {(2*N){1'b0}};
        end
        acc_sum_s = acc_r + addend_s;
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            mplier_r <= {N{1'b0}};
            mcand_r  <= {N{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {(2*N){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mplier_r <= q;
                        mcand_r  <= b;
                        acc_r    <= {{N{1'b0}}, rem};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    // Always N iterations, so latency is independent of operand values.
                    acc_r    <= acc_sum_s;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_iter_s) begin
                        result_r <= acc_sum_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_fp_shift_add_mult.sv
// Scoreboard bench for fp_shift_add_mult: directed cases, reset abort,
// exhaustive N=4 sweep with random input noise, and random operations.
module tb_fp_shift_add_mult;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   q;
    logic [N-1:0]   b;
    logic [N-1:0]   rem;
    logic [2*N-1:0] result;
    logic           busy;
    logic           done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int ops      = 0;
    logic [2*N-1:0] exp_q[$];

    fp_shift_add_mult #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q      (q),
        .b      (b),
        .rem    (rem),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] model(input int qv, input int bv, input int rv);
        int m;
        m = qv * bv + rv;
        return m[2*N-1:0];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy === 1'b1 && done === 1'b1) begin
            chk("busy_and_done", 32'd1, 32'd0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(result), 32'hFFFF_FFFF);
            end else begin
                chk("result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    // One operation from an IDLE negedge; ends at the IDLE negedge after DONE.
    task automatic do_op(input logic [N-1:0] qv, input logic [N-1:0] bv, input logic [N-1:0] rv,
                         input bit noisy, input bit chain,
                         input logic [N-1:0] nq, input logic [N-1:0] nb, input logic [N-1:0] nr);
        logic [2*N-1:0] e;
        e = model(int'(qv), int'(bv), int'(rv));
        q = qv; b = bv; rem = rv; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        ops++;
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (noisy) begin
                q = N'($urandom); b = N'($urandom); rem = N'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_latency", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        if (chain) begin
            q = nq; b = nb; rem = nr; start = 1'b1;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'(e));
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; q = '0; b = '0; rem = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;

        do_op(4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("basic_value", 32'(result), 32'h11);
        do_op(4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("max_value", 32'(result), 32'hF0);
        do_op(4'h0, 4'h9, 4'h7, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("zero_q", 32'(result), 32'h07);
        do_op(4'hA, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("zero_b", 32'(result), 32'h00);
        do_op(4'h6, 4'h7, 4'h0, 1'b1, 1'b1, 4'h3, 4'h4, 4'h5);
        chk("noisy_value", 32'(result), 32'h2A);
        do_op(4'h3, 4'h4, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("chained_value", 32'(result), 32'h11);

        // Reset during the third iteration aborts with no done pulse.
        q = 4'hE; b = 4'hD; rem = 4'h1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        do_op(4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("after_abort", 32'(result), 32'h07);

        for (int qi = 0; qi < 16; qi++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ri = 0; ri < 16; ri++) begin
                    do_op(N'(qi), N'(bi), N'(ri), 1'($urandom_range(0, 1)), 1'b0,
                          4'h0, 4'h0, 4'h0);
                end
            end
        end

        for (int k = 0; k < 100; k++) begin
            logic [N-1:0] a0, a1, a2;
            a0 = N'($urandom); a1 = N'($urandom); a2 = N'($urandom);
            do_op(a0, a1, a2, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(ops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
